// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame sequencer for the UART receiver (start detect, edge/bit counting, strobes).
// Build option UART_RX_CTRL_ERR_FLAGS_EN enables the frame_err / parity_err pulses.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  sampled_bit,
  input  logic                  par_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  parity_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [3:0]            LAST_DATA    = 4'(DATA_W);
  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(32'd8);
  localparam logic [PRESCALE_W-1:0] ONE          = PRESCALE_W'(32'd1);
  localparam logic [PRESCALE_W-1:0] TWO          = PRESCALE_W'(32'd2);

  state_t                  state_r;
  logic [PRESCALE_W-1:0]   prescale_r;
  logic                    par_en_r;
  logic                    perr_r;
  logic                    ferr_r;

  logic [PRESCALE_W-1:0]   check_s;
  logic [PRESCALE_W-1:0]   last_edge_s;
  logic                    wrap_s;
  logic                    at_check_s;
  logic                    at_pre_check_s;
  logic                    at_post_check_s;
  logic                    start_ok_s;
  logic                    stop_chk_s;
  logic                    ferr_next_s;

  // The sampler's registered majority first becomes valid two edges past mid-bit
  assign check_s         = (prescale_r >> 1) + TWO;
  assign last_edge_s     = prescale_r - ONE;
  assign wrap_s          = (edge_cnt == last_edge_s);
  assign at_check_s      = (edge_cnt == check_s);
  assign at_pre_check_s  = (edge_cnt == (check_s - ONE));
  assign at_post_check_s = (edge_cnt == (check_s + ONE));
  assign start_ok_s      = ~RX_IN && (prescale >= MIN_PRESCALE);
  assign stop_chk_s      = (state_r == ST_STOP) && at_check_s;
  assign ferr_next_s     = ferr_r | ~sampled_bit;

  // Frame FSM: counters, sticky error flags and strobes registered one cycle ahead of their edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      prescale_r  <= '0;
      par_en_r    <= 1'b0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= 4'd0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      deser_en   <= 1'b0;
      par_chk_en <= 1'b0;
      data_valid <= 1'b0;
      if (wrap_s) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + ONE;
      end

      case (state_r)
        ST_IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= 4'd0;
          if (start_ok_s) begin
            // The detect cycle is edge 0 of the start bit
            state_r     <= ST_START;
            edge_cnt    <= ONE;
            prescale_r  <= prescale;
            par_en_r    <= PAR_EN;
            perr_r      <= 1'b0;
            ferr_r      <= 1'b0;
            dat_samp_en <= 1'b1;
          end else begin
            dat_samp_en <= 1'b0;
          end
        end

        ST_START: begin
          if (at_check_s && sampled_bit) begin
            state_r     <= ST_IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= 4'd0;
            dat_samp_en <= 1'b0;
          end else if (wrap_s) begin
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_START;
          end
        end

        ST_DATA: begin
          deser_en <= at_pre_check_s;
          if (wrap_s && (bit_cnt == LAST_DATA)) begin
            state_r <= par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            state_r <= ST_DATA;
          end
        end

        ST_PARITY: begin
          par_chk_en <= at_pre_check_s;
          if (at_post_check_s) begin
            perr_r <= perr_r | par_err;
          end else begin
            perr_r <= perr_r;
          end
          if (wrap_s) begin
            state_r <= ST_STOP;
          end else begin
            state_r <= ST_PARITY;
          end
        end

        ST_STOP: begin
          if (stop_chk_s) begin
            ferr_r     <= ferr_next_s;
            data_valid <= ~perr_r & ~ferr_next_s;
          end else begin
            ferr_r <= ferr_r;
          end
          // Leave one edge after the result pulse so a following start edge is caught
          if (at_post_check_s) begin
            state_r     <= ST_IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= 4'd0;
            dat_samp_en <= 1'b0;
          end else begin
            state_r <= ST_STOP;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          edge_cnt    <= '0;
          bit_cnt     <= 4'd0;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_CTRL_ERR_FLAGS_EN
  logic frame_err_r;
  logic parity_err_r;

  // Error pulses are decided at the same point as data_valid, so they land on the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      frame_err_r  <= stop_chk_s & ferr_next_s;
      parity_err_r <= stop_chk_s & perr_r;
    end
  end

  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
`else
  assign frame_err  = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl at prescale 8 with an ideal majority sampler.
module tb_uart_rx_ctrl;

  localparam int PW       = 6;
  localparam int EV_DESER = 1;
  localparam int EV_PCHK  = 2;
  localparam int EV_DV    = 3;
  localparam int EV_FERR  = 4;
  localparam int EV_PERR  = 5;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic          clk         = 1'b0;
  logic          rst         = 1'b0;
  logic          RX_IN       = 1'b1;
  logic          PAR_EN      = 1'b0;
  logic [PW-1:0] prescale    = 6'd8;
  logic          par_err     = 1'b0;
  logic          sampled_bit;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          deser_en;
  logic          par_chk_en;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;

  int         cyc     = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  ev_t        exp_q[$];
  logic [2:0] hist    = 3'b111;
  logic [7:0] shreg   = 8'h00;
  int         t0;

  uart_rx_ctrl #(.PRESCALE_W(PW), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .sampled_bit (sampled_bit),
    .par_err     (par_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // Ideal sampler: registered majority of the three previous line samples
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hist <= {hist[1:0], RX_IN};
  end
  assign sampled_bit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {17'd0, dat_samp_en, edge_cnt, bit_cnt, deser_en, par_chk_en,
            data_valid, frame_err, parity_err};
  endfunction

  task automatic push_ev(input int c, input int kind, input logic [7:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic obs_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq("spurious_pulse", kind, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("ev_kind", kind, e.kind);
      check_eq("ev_cycle", cyc, e.cyc);
      if (kind == EV_DV) check_eq("rx_data", {24'd0, shreg}, {24'd0, e.data});
    end
  endtask

  // Monitor: every strobe or result pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (deser_en) begin
        shreg <= {sampled_bit, shreg[7:1]};
        obs_event(EV_DESER);
      end
      if (par_chk_en) obs_event(EV_PCHK);
      if (data_valid) obs_event(EV_DV);
      if (frame_err)  obs_event(EV_FERR);
      if (parity_err) obs_event(EV_PERR);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drives one frame starting in the current cycle; abort_at >= 0 pulls reset at that offset
  task automatic send_frame(input logic [10:0] bits, input logic pe, input logic pe_err,
                            input int abort_at);
    int   t;
    int   nb;
    int   fin;
    logic ferr;
    logic perr;
    nb      = pe ? 11 : 10;
    t       = cyc;
    PAR_EN  = pe;
    par_err = pe_err;
    ferr    = ~bits[nb-1];
    perr    = pe & pe_err;
    fin     = t + (pe ? 87 : 79);
    for (int k = 0; k < 8; k++) begin
      if (abort_at < 0 || (14 + 8 * k) < abort_at) push_ev(t + 14 + 8 * k, EV_DESER, 8'h00);
    end
    if (abort_at < 0) begin
      if (pe) push_ev(t + 78, EV_PCHK, 8'h00);
      if (!ferr && !perr) push_ev(fin, EV_DV, bits[8:1]);
`ifdef UART_RX_CTRL_ERR_FLAGS_EN
      if (ferr) push_ev(fin, EV_FERR, 8'h00);
      if (perr) push_ev(fin, EV_PERR, 8'h00);
`endif
    end
    for (int c = 0; c < nb * 8; c++) begin
      RX_IN = bits[c/8];
      if (c == 16) begin
        PAR_EN   = ~pe;
        prescale = 6'd16;
      end
      if (c == abort_at) begin
        rst = 1'b0;
        #1;
        check_eq("abort_outs", all_outs(), 32'd0);
        check_eq("abort_pending", exp_q.size(), 32'd0);
        RX_IN    = 1'b1;
        PAR_EN   = pe;
        prescale = 6'd8;
        step();
        rst = 1'b1;
        return;
      end
      step();
    end
    RX_IN    = 1'b1;
    PAR_EN   = pe;
    prescale = 6'd8;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", all_outs(), 32'd0);
    rst = 1'b1;
    idle(2);
    check_eq("idle_outs", all_outs(), 32'd0);

    send_frame(11'b0_1010101010, 1'b0, 1'b0, -1);
    idle(5);

    // One-cycle low glitch: START is entered, then rejected at the check edge
    t0    = cyc;
    RX_IN = 1'b0;
    step();
    RX_IN = 1'b1;
    check_eq("glitch_start", {dat_samp_en, edge_cnt}, {1'b1, 6'd1});
    idle(5);
    check_eq("glitch_hold_cyc", cyc, t0 + 6);
    check_eq("glitch_hold", dat_samp_en, 1'b1);
    step();
    check_eq("glitch_idle", {dat_samp_en, edge_cnt, bit_cnt}, 11'd0);
    idle(5);

    // Prescale below 8 keeps the block in IDLE
    prescale = 6'd6;
    RX_IN    = 1'b0;
    step();
    check_eq("small_prescale_1", dat_samp_en, 1'b0);
    step();
    check_eq("small_prescale_2", dat_samp_en, 1'b0);
    RX_IN    = 1'b1;
    prescale = 6'd8;
    idle(5);

    send_frame(11'b11100000110, 1'b1, 1'b0, -1);
    idle(3);
    send_frame(11'b11100000110, 1'b1, 1'b1, -1);
    idle(3);
    send_frame(11'b0_0000110110, 1'b0, 1'b0, -1);
    idle(3);

    // Back-to-back: the second start edge lands on the first re-arm cycle
    send_frame(11'b0_1010101010, 1'b0, 1'b0, -1);
    send_frame(11'b0_1110010100, 1'b0, 1'b0, -1);
    idle(3);

    send_frame(11'b0_1001100110, 1'b0, 1'b0, 40);
    idle(3);
    send_frame(11'b0_1111100000, 1'b0, 1'b0, -1);
    idle(10);

    check_eq("pending_events", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receiver datapath. It detects the start edge on `RX_IN`, runs the oversampling edge counter and bit counter, and strobes the data sampler, deserializer, parity checker and stop checker at the correct edges. It rejects start glitches, gates `data_valid` on parity and stop results, and returns to IDLE inside the stop bit so back-to-back frames are received. It sits between the line input and the sampler/deserializer/checker blocks inside the receiver top.

## Interface
- `PRESCALE_W`, 6: width of `prescale` and `edge_cnt`.
- `DATA_W`, 8: data bits per frame.

Ports:
- `clk`  in  1  receiver clock; `prescale` cycles per serial bit.
- `rst`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, idle high.
- `PAR_EN`  in  1  parity bit present; latched at start detect.
- `prescale`  in  PRESCALE_W  oversampling ratio; legal values are even and ≥8 (8, 16, 32 in use); latched at start detect.
- `sampled_bit`  in  1  majority-voted bit from the sampler; valid at edge C.
- `par_err`  in  1  parity checker result; valid one cycle after `par_chk_en`.
- `dat_samp_en`  out  1  sampler enable; high in every non-IDLE state.
- `edge_cnt`  out  PRESCALE_W  edge position within the current bit.
- `bit_cnt`  out  4  bit index: 0 = start, 1..DATA_W = data, DATA_W+1 = parity or stop.
- `deser_en`  out  1  one-cycle shift strobe per data bit.
- `par_chk_en`  out  1  one-cycle parity check strobe.
- `data_valid`  out  1  one-cycle pulse when a frame is good.
- `frame_err`  out  1  one-cycle pulse when the stop bit is bad.
- `parity_err`  out  1  one-cycle pulse when parity is bad.

## Operation
- Check edge: C = prescale_q/2 + 2. This is the first edge at which the registered majority from edges prescale/2−1 .. prescale/2+1 is valid.
- **IDLE**
  - `edge_cnt` = 0, `bit_cnt` = 0.
  - On `RX_IN`==0, latch `PAR_EN` and `prescale`, then go to START with `edge_cnt` = 1. The detect cycle counts as edge 0.
  - If `prescale` < 8, the block stays in IDLE.
- **Edge and bit counting**
  - `edge_cnt` increments each cycle and wraps to 0 after prescale_q−1.
  - `bit_cnt` increments on each wrap.
- **START**
  - At edge C: if `sampled_bit`==1 (glitch), go to IDLE next cycle and clear both counters. Nothing else is strobed.
  - At wrap: go to DATA.
- **DATA**
  - `deser_en` is high at edge C of each data bit.
  - At wrap with `bit_cnt`==DATA_W: go to PARITY if par_en_q, else STOP.
- **PARITY**
  - `par_chk_en` is high at edge C.
  - At edge C+1, `par_err` is captured into a sticky flag `perr_q`.
  - At wrap: go to STOP.
- **STOP**
  - At edge C, `sampled_bit`==0 sets `ferr_q`.
  - At edge C+1, exactly one of the following pulses, then the block goes to IDLE:
    - `data_valid`, if !perr_q && !ferr_q;
    - otherwise `frame_err` = ferr_q and `parity_err` = perr_q.
- `perr_q` and `ferr_q` clear on entry to START.
- Changes to `PAR_EN` or `prescale` mid-frame have no effect until the next start detect.
- `RX_IN` is ignored outside IDLE.

## Timing
- Reset values: state IDLE; `edge_cnt`, `bit_cnt`, `dat_samp_en`, `deser_en`, `par_chk_en`, `data_valid`, `frame_err`, `parity_err`, `perr_q`, `ferr_q` all 0.
- Reset mid-frame aborts the frame immediately with no pulses.
- All outputs are registered.
- Start detected at cycle T:
  - `data_valid`/err pulse in cycle T + (DATA_W+1)·prescale + C + 1 without parity;
  - plus prescale cycles with parity;
  - for prescale=8: T+79 without parity, T+87 with parity.
- Re-arm: IDLE is entered at edge C+2 of the stop bit. A start edge arriving on that cycle is detected.
- Glitch exit: IDLE at cycle T+C+1. For prescale=8 that is T+7, and no `deser_en` pulses occur.

## Configuration
- `UART_RX_CTRL_ERR_FLAGS_EN`
  - Defined: `frame_err` and `parity_err` pulse as specified.
  - Undefined: both are tied to 0 and the error flag logic is removed.
  - `data_valid` suppression on error is identical in both builds.

## Test plan
All cases use prescale=8, and the bench drives `sampled_bit` from an ideal majority model of `RX_IN`.
- Frame 10'b1010101010 LSB-first, PAR_EN=0 → 8 `deser_en` pulses at T+14+8k; `data_valid` at T+79; shifted data 0x55.
- 1-cycle low glitch on idle line → START entered, IDLE at T+7; no `deser_en`, no pulses.
- PAR_EN=1, frame 11'b11100000110, bench `par_err`=0 → `par_chk_en` at T+78, `data_valid` at T+87.
- PAR_EN=1, bench `par_err`=1 → `parity_err` at T+87, no `data_valid`.
- Stop bit forced 0 (10'b0000110110) → `frame_err` at T+79, no `data_valid`.
- Two frames back-to-back with the second start edge at the first frame's T+80 → both `data_valid`.
- `rst` low at T+40 → all outputs 0 immediately; the next frame is received normally.
